seg_msg_scroller: RTL and testbench

Registered, parametrised successor to the calculator's combinational state-to-7-segment message decoder. Maps the calculator FSM state and calc mode to a text message of up to MSG_LEN glyphs. Messages that fit on NUM_DIGITS digits are shown statically. Longer messages scroll left on a divided tick, and an optional blink mode flashes the display. Sits between the top-level calculator FSM and the DE-10 Lite HEX digit pins.

---
 rtl/seg_msg_pkg.sv | 92 +++++++++
 rtl/seg_msg_scroller_if.sv | 29 ++
 rtl/seg_msg_scroller_glyph_rom.sv | 41 ++++
 rtl/seg_msg_scroller.sv | 135 +++++++++++++
 tb/tb_seg_msg_scroller.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/seg_msg_pkg.sv
// Shared types for the 7-segment message scroller.
// Holds the glyph alphabet, the calculator state codes and the message table
// (length and glyph lookup) used by the scroller datapath.
package seg_msg_pkg;

    localparam int unsigned MAX_MSG_LEN = 16;
    localparam int unsigned STATE_W     = 3;
    localparam int unsigned SEG_W       = 7;
    // Wide enough for lengths 0..16 and ring positions up to 16+5.
    localparam int unsigned LEN_W       = 5;

    localparam logic [STATE_W-1:0] ST_INP  = 3'b000;
    localparam logic [STATE_W-1:0] ST_INP1 = 3'b001;
    localparam logic [STATE_W-1:0] ST_MODE = 3'b010;
    localparam logic [STATE_W-1:0] ST_INP2 = 3'b011;
    localparam logic [STATE_W-1:0] ST_OUT  = 3'b100;
    localparam logic [STATE_W-1:0] ST_ERR  = 3'b101;

    typedef enum logic [4:0] {
        GL_BLANK,
        GL_0, GL_1, GL_2, GL_3, GL_4, GL_5, GL_6, GL_7, GL_8, GL_9,
        GL_A, GL_C, GL_E, GL_I, GL_N, GL_O, GL_P, GL_R, GL_S, GL_T,
        GL_U, GL_D, GL_Y, GL_L
    } glyph_t;

    // Number of glyphs in the message for a given state/mode.
    function automatic logic [LEN_W-1:0] msg_length(input logic [STATE_W-1:0] st,
                                                     input logic cm);
        logic [LEN_W-1:0] len;
        len = '0;
        case (st)
            ST_INP:  len = LEN_W'(3);
            ST_INP1: len = LEN_W'(4);
            ST_MODE: len = cm ? LEN_W'(5) : LEN_W'(4);
            ST_INP2: len = LEN_W'(4);
            ST_OUT:  len = LEN_W'(3);
            ST_ERR:  len = LEN_W'(5);
            default: len = '0;
        endcase
        return len;
    endfunction

    // Glyph at position idx of the message; blank beyond the message.
    function automatic glyph_t msg_glyph(input logic [STATE_W-1:0] st,
                                         input logic cm,
                                         input logic [LEN_W-1:0] idx);
        glyph_t g;
        g = GL_BLANK;
        case (st)
            ST_INP, ST_INP1, ST_INP2: begin
                case (idx)
                    LEN_W'(0): g = GL_I;
                    LEN_W'(1): g = GL_N;
                    LEN_W'(2): g = GL_P;
                    LEN_W'(3): g = (st == ST_INP1) ? GL_1 : (st == ST_INP2) ? GL_2 : GL_BLANK;
                    default:   g = GL_BLANK;
                endcase
            end
            ST_MODE: begin
                case (idx)
                    LEN_W'(0): g = cm ? GL_S : GL_C;
                    LEN_W'(1): g = cm ? GL_C : GL_U;
                    LEN_W'(2): g = cm ? GL_I : GL_S;
                    LEN_W'(3): g = cm ? GL_N : GL_T;
                    LEN_W'(4): g = cm ? GL_T : GL_BLANK;
                    default:   g = GL_BLANK;
                endcase
            end
            ST_OUT: begin
                case (idx)
                    LEN_W'(0): g = GL_O;
                    LEN_W'(1): g = GL_U;
                    LEN_W'(2): g = GL_T;
                    default:   g = GL_BLANK;
                endcase
            end
            ST_ERR: begin
                case (idx)
                    LEN_W'(0): g = GL_E;
                    LEN_W'(1): g = GL_R;
                    LEN_W'(2): g = GL_R;
                    LEN_W'(3): g = GL_O;
                    LEN_W'(4): g = GL_R;
                    default:   g = GL_BLANK;
                endcase
            end
            default: g = GL_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_msg_scroller_if.sv
// Bus between the calculator FSM (master) and the message scroller (slave).
//   state, calcmod     : calculator state code and calc mode
//   scroll_en, blink_en: display mode controls
//   display_seg        : active-low {g..a} per digit, leftmost digit in MSBs
//   msg_done           : one-cycle pulse on scroll wrap
interface seg_msg_scroller_if
    import seg_msg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned DISP_W = SEG_W * NUM_DIGITS;

    logic [STATE_W-1:0] state;
    logic               calcmod;
    logic               scroll_en;
    logic               blink_en;
    logic [DISP_W-1:0]  display_seg;
    logic               msg_done;

    modport master (
        output state, calcmod, scroll_en, blink_en,
        input  display_seg, msg_done
    );

    modport slave (
        input  state, calcmod, scroll_en, blink_en,
        output display_seg, msg_done
    );
endinterface

// File: rtl/seg_msg_scroller_glyph_rom.sv
// Glyph to active-low 7-segment pattern {g,f,e,d,c,b,a}.
//   glyph : glyph code
//   seg_c : combinational segment pattern (1 = segment off)
module seg_glyph_rom
    import seg_msg_pkg::*;
(
    input  glyph_t             glyph,
    output logic [SEG_W-1:0]   seg_c
);
    always_comb begin
        seg_c = 7'b1111111;
        case (glyph)
            GL_0:    seg_c = 7'b1000000;
            GL_1:    seg_c = 7'b1111001;
            GL_2:    seg_c = 7'b0100100;
            GL_3:    seg_c = 7'b0110000;
            GL_4:    seg_c = 7'b0011001;
            GL_5:    seg_c = 7'b0010010;
            GL_6:    seg_c = 7'b0000010;
            GL_7:    seg_c = 7'b1111000;
            GL_8:    seg_c = 7'b0000000;
            GL_9:    seg_c = 7'b0010000;
            GL_A:    seg_c = 7'b0001000;
            GL_C:    seg_c = 7'b1000110;
            GL_E:    seg_c = 7'b0000110;
            // Same pattern as the legacy decoder, which drew 'i' like '1'.
            GL_I:    seg_c = 7'b1111001;
            GL_N:    seg_c = 7'b0101011;
            GL_O:    seg_c = 7'b1000000;
            GL_P:    seg_c = 7'b0001100;
            GL_R:    seg_c = 7'b0101111;
            GL_S:    seg_c = 7'b0010010;
            GL_T:    seg_c = 7'b0000111;
            GL_U:    seg_c = 7'b1100011;
            GL_D:    seg_c = 7'b0100001;
            GL_Y:    seg_c = 7'b0010001;
            GL_L:    seg_c = 7'b1000111;
            default: seg_c = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/seg_msg_scroller.sv
// Registered state-to-message display driver for the calculator HEX digits.
// Short messages are shown left-aligned; longer ones scroll left through a
// ring of the message plus one blank, one step per TICK_DIV clocks. An
// optional blink blanks the display on alternate BLINK_DIV-cycle phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of seg_msg_scroller_if (inputs state, calcmod,
//                scroll_en, blink_en; outputs display_seg, msg_done)
module seg_msg_scroller
    import seg_msg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned MSG_LEN    = 8,
    parameter int unsigned TICK_DIV   = 12500000,
    parameter int unsigned BLINK_DIV  = 25000000
)(
    input  logic                clk,
    input  logic                rst_n,
    seg_msg_scroller_if.slave   bus
);
    localparam int unsigned DISP_W  = SEG_W * NUM_DIGITS;
    localparam int unsigned TICK_W  = $clog2(TICK_DIV);
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
    localparam int unsigned KEY_W   = STATE_W + 1;

    logic [KEY_W-1:0]   prev_key;
    logic               prev_scroll;
    logic [LEN_W-1:0]   offset;
    logic [TICK_W-1:0]  tick_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_ph;

    logic [KEY_W-1:0]   key_c;
    logic [LEN_W-1:0]   raw_len_c;
    logic [LEN_W-1:0]   msg_len_c;
    logic               scrolling_c;
    logic               changed_c;
    logic [LEN_W-1:0]   offset_nxt_c;
    logic [TICK_W-1:0]  tick_nxt_c;
    logic               wrap_c;
    logic [BLINK_W-1:0] blink_cnt_nxt_c;
    logic               blink_ph_nxt_c;
    logic [DISP_W-1:0]  digits_c;
    logic [DISP_W-1:0]  display_nxt_c;

    // Message length, capped to the configured maximum.
    always_comb begin
        key_c       = {bus.state, bus.calcmod};
        raw_len_c   = msg_length(bus.state, bus.calcmod);
        msg_len_c   = (raw_len_c > LEN_W'(MSG_LEN)) ? LEN_W'(MSG_LEN) : raw_len_c;
        scrolling_c = bus.scroll_en && (msg_len_c > LEN_W'(NUM_DIGITS));
        changed_c   = (key_c != prev_key) || (bus.scroll_en != prev_scroll);
    end

    // Scroll offset and tick; an input change restarts the message and wins over a tick.
    always_comb begin
        offset_nxt_c = offset;
        tick_nxt_c   = tick_cnt;
        wrap_c       = 1'b0;
        if (changed_c || !scrolling_c) begin
            offset_nxt_c = '0;
            tick_nxt_c   = '0;
        end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
            tick_nxt_c = '0;
            // Ring period is len+1, so the last offset equals len.
            if (offset == msg_len_c) begin
                offset_nxt_c = '0;
                wrap_c       = 1'b1;
            end else begin
                offset_nxt_c = offset + LEN_W'(1);
            end
        end else begin
            tick_nxt_c = tick_cnt + TICK_W'(1);
        end
    end

    // Free-running blink divider.
    always_comb begin
        blink_cnt_nxt_c = blink_cnt + BLINK_W'(1);
        blink_ph_nxt_c  = blink_ph;
        if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_nxt_c = '0;
            blink_ph_nxt_c  = ~blink_ph;
        end
    end

    // Per-digit ring lookup, using the offset being registered this cycle.
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        logic [LEN_W-1:0] pos_c;
        glyph_t           glyph_c;
        logic [SEG_W-1:0] seg_c;

        always_comb begin
            pos_c = offset_nxt_c + LEN_W'(d);
            // offset < period and d < len when scrolling, so one subtract suffices.
            if (scrolling_c && (pos_c > msg_len_c)) begin
                pos_c = pos_c - (msg_len_c + LEN_W'(1));
            end
            glyph_c = (pos_c < msg_len_c) ? msg_glyph(bus.state, bus.calcmod, pos_c) : GL_BLANK;
        end

        seg_glyph_rom u_rom (
            .glyph (glyph_c),
            .seg_c (seg_c)
        );

        assign digits_c[DISP_W - SEG_W*(d+1) +: SEG_W] = seg_c;
    end

    always_comb begin
        display_nxt_c = (bus.blink_en && blink_ph_nxt_c) ? '1 : digits_c;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_key        <= '0;
            prev_scroll     <= 1'b0;
            offset          <= '0;
            tick_cnt        <= '0;
            blink_cnt       <= '0;
            blink_ph        <= 1'b0;
            bus.display_seg <= '1;
            bus.msg_done    <= 1'b0;
        end else begin
            prev_key        <= key_c;
            prev_scroll     <= bus.scroll_en;
            offset          <= offset_nxt_c;
            tick_cnt        <= tick_nxt_c;
            blink_cnt       <= blink_cnt_nxt_c;
            blink_ph        <= blink_ph_nxt_c;
            bus.display_seg <= display_nxt_c;
            bus.msg_done    <= wrap_c;
        end
    end
endmodule

// File: tb/tb_seg_msg_scroller.sv
// Self-checking bench for seg_msg_scroller: directed steps, scoreboard queue
// of expected display/msg_done values compared one cycle after each step.
module tb_seg_msg_scroller;
    localparam int unsigned ND = 4;
    localparam int unsigned ML = 8;
    localparam int unsigned TD = 4;
    localparam int unsigned BD = 3;
    localparam int unsigned DW = 7 * ND;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_msg_scroller_if #(.NUM_DIGITS(ND)) bus ();

    seg_msg_scroller #(
        .NUM_DIGITS (ND),
        .MSG_LEN    (ML),
        .TICK_DIV   (TD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW:0] exp_q[$];
    string       tag_q[$];

    localparam logic [DW-1:0] BLANK = '1;

    function automatic logic [6:0] ch2seg(input byte c);
        case (c)
            "i", "1": return 7'b1111001;
            "n":      return 7'b0101011;
            "P":      return 7'b0001100;
            "2":      return 7'b0100100;
            "C":      return 7'b1000110;
            "u":      return 7'b1100011;
            "S":      return 7'b0010010;
            "t":      return 7'b0000111;
            "O":      return 7'b1000000;
            "E":      return 7'b0000110;
            "r":      return 7'b0101111;
            default:  return 7'b1111111;
        endcase
    endfunction

    // Expected display for msg at ring offset off (scroll) or left-aligned.
    function automatic logic [DW-1:0] render(input string msg, input int off, input bit scroll);
        logic [DW-1:0] r;
        int  len;
        int  k;
        byte c;
        r   = '0;
        len = msg.len();
        for (int i = 0; i < int'(ND); i++) begin
            k = scroll ? (off + i) % (len + 1) : i;
            c = (k < len) ? msg[k] : 8'h20;
            r = {r[DW-8:0], ch2seg(c)};
        end
        return r;
    endfunction

    task automatic push(input logic [DW-1:0] seg, input logic done, input string tag);
        exp_q.push_back({done, seg});
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        logic [DW:0] e;
        string t;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_empty: got nothing to compare, required an entry");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_checks++;
        assert (bus.display_seg === e[DW-1:0]) else begin
            n_fail++;
            $error("FAIL %s display_seg: got %b required %b", t, bus.display_seg, e[DW-1:0]);
        end
        n_checks++;
        assert (bus.msg_done === e[DW]) else begin
            n_fail++;
            $error("FAIL %s msg_done: got %b required %b", t, bus.msg_done, e[DW]);
        end
    endtask

    task automatic cycle(input logic [DW-1:0] seg, input logic done, input string tag);
        push(seg, done, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held while a scrolling message is selected.
        rst_n         = 1'b0;
        bus.state     = 3'b010;
        bus.calcmod   = 1'b1;
        bus.scroll_en = 1'b1;
        bus.blink_en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push(BLANK, 1'b0, "reset_hold");
        check_out();

        // Release with state 000.
        bus.state   = 3'b000;
        bus.calcmod = 1'b0;
        rst_n       = 1'b1;
        cycle(render("inP", 0, 1'b0), 1'b0, "release_inP");

        // Static four-glyph message, stable.
        bus.state = 3'b011;
        cycle(28'b1111001_0101011_0001100_0100100, 1'b0, "static_inP2");
        for (int i = 0; i < 100; i++)
            cycle(28'b1111001_0101011_0001100_0100100, 1'b0, "static_hold");

        // Scrolling "SCint", ring period 6, step every 4 cycles.
        bus.state   = 3'b010;
        bus.calcmod = 1'b1;
        for (int e = 0; e < 40; e++)
            cycle(render("SCint", (e / 4) % 6, 1'b1), (e == 24), "scroll");

        // Offset is 3 and the next edge is a tick: the mode change wins.
        bus.calcmod = 1'b0;
        for (int i = 0; i < 8; i++)
            cycle(render("CuSt", 0, 1'b0), 1'b0, "change_CuSt");

        // Restart scrolling, then reset mid-scroll.
        bus.calcmod = 1'b1;
        for (int e = 0; e < 6; e++)
            cycle(render("SCint", e / 4, 1'b1), 1'b0, "scroll2");
        rst_n = 1'b0;
        #1;
        push(BLANK, 1'b0, "reset_async");
        check_out();
        repeat (2) @(posedge clk);
        #1;
        push(BLANK, 1'b0, "reset_mid");
        check_out();
        rst_n = 1'b1;
        for (int e = 0; e < 8; e++)
            cycle(render("SCint", e / 4, 1'b1), 1'b0, "restart");

        // Blink from a fresh reset: phase flips every 3 cycles.
        rst_n         = 1'b0;
        bus.state     = 3'b100;
        bus.calcmod   = 1'b0;
        bus.scroll_en = 1'b0;
        bus.blink_en  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 9; e++)
            cycle(((e / 3) % 2 != 0) ? BLANK : render("Out", 0, 1'b0), 1'b0, "blink");
        bus.blink_en = 1'b0;
        cycle(render("Out", 0, 1'b0), 1'b0, "blink_off");
        cycle(render("Out", 0, 1'b0), 1'b0, "blink_off_hold");

        // Undefined state shows blank.
        bus.state = 3'b111;
        for (int i = 0; i < 3; i++)
            cycle(BLANK, 1'b0, "undef_state");

        // Long message with scrolling disabled: first four glyphs, no msg_done.
        bus.state = 3'b101;
        for (int i = 0; i < 30; i++)
            cycle(render("ErrOr", 0, 1'b0), 1'b0, "static_Erro");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
